// File: rtl/rpn_stack_ctrl.sv
// rpn_stack_ctrl: reverse-Polish execution controller in front of a LIFO.
// Tracks occupancy locally so rejected commands never strobe the stack.
module rpn_stack_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int DW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             unf,
  output logic [DW-1:0]    depth,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PUSH = 3'd1;
  localparam logic [2:0] S_POP1 = 3'd2;
  localparam logic [2:0] S_POPD = 3'd3;
  localparam logic [2:0] S_POP2 = 3'd4;
  localparam logic [2:0] S_EXEC = 3'd5;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;

  localparam logic [DW-1:0] FULL = DW'(DEPTH);
  localparam logic [DW-1:0] TWO  = DW'(2);

  logic [2:0]       state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic [WIDTH:0]   sum;
  logic             accept;
  logic [DW-1:0]    depth_nxt;

  assign cmd_ready = (state == S_IDLE) & ~rst;
  assign accept    = cmd_valid & cmd_ready;
  assign stk_push  = (state == S_PUSH) | (state == S_EXEC);
  assign stk_pop   = (state == S_POP1) | (state == S_POP2);
  assign depth_nxt = depth + DW'(stk_push) - DW'(stk_pop);

  // a is the element below the top (live on stk_dout), b was the top
  always_comb begin
    sum     = {1'b0, stk_dout} + {1'b0, b_q};
    alu_res = stk_dout ^ b_q;
    alu_c   = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
      end
      OP_SUB: begin
        alu_res = stk_dout - b_q;
        alu_c   = stk_dout < b_q;
      end
      OP_AND:  alu_res = stk_dout & b_q;
      OP_OR:   alu_res = stk_dout | b_q;
      default: alu_res = stk_dout ^ b_q;
    endcase
  end

  always_comb begin
    stk_din = '0;
    if (state == S_PUSH) stk_din = imm_q;
    if (state == S_EXEC) stk_din = alu_res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= OP_NOP;
      imm_q     <= '0;
      b_q       <= '0;
      depth     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      depth     <= depth_nxt;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q <= cmd_op;
            case (cmd_op)
              OP_NOP: ;
              OP_PUSH: begin
                if (depth == FULL) begin
                  ovf <= 1'b1;
                end else begin
                  imm_q <= cmd_imm;
                  state <= S_PUSH;
                end
              end
              OP_POP: begin
                if (depth == '0) unf <= 1'b1;
                else state <= S_POP1;
              end
              default: begin
                if (depth < TWO) unf <= 1'b1;
                else state <= S_POP1;
              end
            endcase
          end
        end
        S_PUSH: state <= S_IDLE;
        S_POP1: state <= (op_q == OP_POP) ? S_POPD : S_POP2;
        S_POPD: begin
          res_data  <= stk_dout;
          res_valid <= 1'b1;
          state     <= S_IDLE;
        end
        S_POP2: begin
          b_q   <= stk_dout;
          state <= S_EXEC;
        end
        S_EXEC: begin
          res_data  <= alu_res;
          carry     <= alu_c;
          zero      <= (alu_res == '0);
          res_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rpn_stack_ctrl.md
# rpn_stack_ctrl

Stack-machine execution controller sitting directly upstream of the `stack` LIFO: it accepts opcode commands over a valid/ready handshake, drives the stack's push/pop/data_in strobes, reads its data_out, and performs two-operand ALU operations in reverse-Polish order. It tracks stack occupancy itself so that overflow and underflow are rejected before any strobe reaches the stack. Result, flags and error pulses go to the core's datapath.

## Interface
- WIDTH, 8: data width; must equal the attached stack's WIDTH.
- DEPTH, 4: stack capacity; must equal the attached stack's DEPTH.
- DW, $clog2(DEPTH+1): derived width of `depth`.

- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset; shared with the attached stack.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller idle; a command is accepted on an edge where cmd_valid and cmd_ready are both high.
- cmd_op  in  3  000 NOP, 001 PUSH, 010 POP, 011 ADD, 100 SUB, 101 AND, 110 OR, 111 XOR.
- cmd_imm  in  WIDTH  PUSH operand; sampled at acceptance.
- res_valid  out  1  one-cycle pulse; res_data is valid.
- res_data  out  WIDTH  popped value for POP, or ALU result.
- carry  out  1  ADD carry-out / SUB borrow.
- zero  out  1  last ALU result was zero.
- ovf  out  1  one-cycle pulse: PUSH rejected, stack full.
- unf  out  1  one-cycle pulse: POP or ALU op rejected, not enough operands.
- depth  out  DW  current occupancy, 0..DEPTH.
- stk_push  out  1  to stack push.
- stk_pop  out  1  to stack pop.
- stk_din  out  WIDTH  to stack data_in.
- stk_dout  in  WIDTH  from stack data_out.

## Operation
- Stack contract: on the edge where stk_push is high, the stack stores stk_din. On the edge where stk_pop is high, the stack loads the top element into data_out and holds it until the next pop. The controller never asserts stk_push and stk_pop together.
- FSM states: IDLE, PUSH, POP1, POPD, POP2, EXEC. cmd_ready = (state==IDLE) & ~rst.
- Acceptance checks use the depth value at the accept edge:
  - PUSH with depth==DEPTH: ovf pulse.
  - POP with depth==0: unf pulse.
  - ALU op with depth<2: unf pulse.
  - A rejected command is consumed, generates no strobes, and the FSM stays in IDLE.
- NOP: consumed; no effect.
- PUSH: IDLE→PUSH. PUSH state drives stk_push=1 and stk_din=imm register. Returns to IDLE. No res_valid.
- POP: IDLE→POP1 (stk_pop=1)→POPD. POPD captures stk_dout into res_data and sets res_valid for the following cycle. Returns to IDLE.
- ALU op: IDLE→POP1 (stk_pop=1, pops b)→POP2 (stk_pop=1, b_reg<=stk_dout, pops a)→EXEC.
  - EXEC drives stk_push=1 and stk_din = a op b, with a = stk_dout and b = b_reg.
  - SUB computes a−b, where a is the element that was below the top.
  - The EXEC edge loads res_data, carry and zero, and sets res_valid. Returns to IDLE.
- Arithmetic: ADD uses a WIDTH+1-bit sum; carry = bit WIDTH. SUB: carry = (a<b) (borrow), result modulo 2^WIDTH. AND/OR/XOR clear carry. zero = (result==0), updated only by ALU ops. POP and PUSH leave carry and zero unchanged.
- depth: +1 on each stk_push edge, −1 on each stk_pop edge. An ALU op therefore nets −1. depth never leaves 0..DEPTH.

## Timing
- Reset (asynchronous, immediate): state=IDLE, depth=0. res_valid, res_data, carry, zero, ovf, unf, stk_push, stk_pop, stk_din all 0. cmd_ready is 0 while rst is high and 1 from the first cycle after release.
- Reset mid-operation aborts the command with no further strobes. Stack and controller are reset together, so depth stays consistent.
- Latencies, counted from accept edge E0:
  - PUSH: stack write at E1; cmd_ready high again after E1.
  - POP: pops at E1; res_valid high in the cycle after E2.
  - ALU op: pops at E1 and E2, push at E3; res_valid high in the cycle after E3.
  - ovf/unf: high in the cycle after E0.
- res_valid, ovf and unf are each high for exactly one cycle. res_valid coincides with cmd_ready=1, so back-to-back commands are allowed.
- res_data, carry and zero hold their values until the next update.

## Test plan
- Reset; PUSH 0x05, PUSH 0x03, SUB → res_data=0x02, carry=0, zero=0, depth=1. Then POP → res_data=0x02, depth=0.
- PUSH 0xF0, PUSH 0x20, ADD → res_data=0x10, carry=1. PUSH 0x03, PUSH 0x05, SUB → 0xFE, carry=1. PUSH 0x5A, PUSH 0x5A, XOR → 0x00, zero=1, carry=0.
- Four PUSHes (depth=4), then fifth PUSH 0x77 → one-cycle ovf, no stk_push, depth=4. POP ×4 returns values in LIFO order, then POP → unf, depth=0.
- depth=1, ADD → unf one cycle later, no stk_pop, depth=1, stack contents intact.
- cmd_valid held high with ADD, depth=3:
  - cmd_ready low for 3 cycles.
  - stk_pop high in cycles 1–2, stk_push high in cycle 3.
  - res_valid and cmd_ready high together in cycle 4.
  - The next ADD is accepted at that edge.
- Assert rst asynchronously during POP2 → every output 0 immediately, depth=0. After release: IDLE, cmd_ready=1, and PUSH 0x11 then POP returns 0x11.
